// File: rtl/fetch_queue.sv
// fetch_queue: instruction FIFO between instruction memory and decode.
// Holds DEPTH {inst, addr, irq} entries and presents the head combinationally
// (first-word-fall-through). When the queue is empty the head shows a NOP.
// Hold stalls only the pop side, and flush empties the queue on the next edge.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. Valid never depends on ready. inst_ready_o depends only
// on the registered count. inst_valid_o depends only on the registered count
// and on hold_flag_i. flush_i cancels any transfer in the same cycle.
module fetch_queue #(
    parameter int              DEPTH      = 4,
    parameter int              INST_W     = 32,
    parameter int              ADDR_W     = 32,
    parameter int              IRQ_W      = 8,
    parameter logic [2:0]      HOLD_LEVEL = 3'b010,
    parameter logic [INST_W-1:0] NOP      = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    input  logic [IRQ_W-1:0]           interrupt_flag_i,
    input  logic                       inst_valid_i,
    output logic                       inst_ready_o,
    input  logic [2:0]                 hold_flag_i,
    input  logic                       flush_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic [IRQ_W-1:0]           interrupt_flag_o,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry storage; the three fields share one index so they always stay together
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [IRQ_W-1:0]  irq_mem  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic empty;
    logic hold;
    logic push;
    logic pop;

    // Handshake qualifiers; flush cancels both sides
    always_comb begin
        empty        = (count == '0);
        hold         = (hold_flag_i >= HOLD_LEVEL);
        inst_ready_o = (count != CW'(DEPTH));
        inst_valid_o = ~empty & ~hold;
        push         = inst_valid_i & inst_ready_o & ~flush_i;
        pop          = inst_valid_o & inst_ready_i & ~flush_i;
    end

    // Head presentation: the stored head when non-empty, otherwise NOP/0/0
    always_comb begin
        inst_o           = NOP;
        inst_addr_o      = '0;
        interrupt_flag_o = '0;
        if (!empty) begin
            inst_o           = inst_mem[rd_ptr];
            inst_addr_o      = addr_mem[rd_ptr];
            interrupt_flag_o = irq_mem[rd_ptr];
        end
    end

    assign count_o = count;

    // Pointer and occupancy state; flush returns everything to the reset state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= inst_i;
            addr_mem[wr_ptr] <= inst_addr_i;
            irq_mem[wr_ptr]  <= interrupt_flag_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a queue-based reference
// model, a per-cycle compare process and hand-computed literal expectations.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [7:0]  interrupt_flag_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [2:0]  hold_flag_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [7:0]  interrupt_flag_o;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [2:0]  count_o;

    int checks = 0;
    int passes = 0;

    // Model: entries packed as {irq, addr, inst}
    logic [71:0] exp_q[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .interrupt_flag_i(interrupt_flag_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .hold_flag_i(hold_flag_i), .flush_i(flush_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .interrupt_flag_o(interrupt_flag_o),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .count_o(count_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model update: a FIFO of whole entries, emptied by reset or flush
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            bit m_push, m_pop;
            m_push = inst_valid_i && (exp_q.size() != DEPTH) && !flush_i;
            m_pop  = (exp_q.size() != 0) && (hold_flag_i < 3'b010) && inst_ready_i && !flush_i;
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) exp_q.push_back({interrupt_flag_i, inst_addr_i, inst_i});
            end
        end
    end

    // Compare process: every falling edge, outputs against the model
    always @(negedge clk) begin
        logic [71:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : {8'h00, 32'h0, NOP};
        chk("cyc_count", 72'(count_o), 72'(exp_q.size()));
        chk("cyc_ready", 72'(inst_ready_o), 72'(exp_q.size() != DEPTH));
        chk("cyc_valid", 72'(inst_valid_o), 72'((exp_q.size() != 0) && (hold_flag_i < 3'b010)));
        chk("cyc_head", {interrupt_flag_o, inst_addr_o, inst_o}, head);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                            input logic [7:0] irq);
        inst_valid_i     = v;
        inst_i           = inst;
        inst_addr_i      = addr;
        interrupt_flag_i = irq;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_count", 72'(count_o), 72'd0);
        chk("rst_ready", 72'(inst_ready_o), 72'd1);
        chk("rst_valid", 72'(inst_valid_o), 72'd0);
        chk("rst_inst", 72'(inst_o), 72'(NOP));
        rst = 1'b0;
        tick();

        // 1: single push, visible next cycle
        set_push(1'b1, 32'h00500093, 32'h0, 8'h00);
        tick();
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        chk("t1_inst", 72'(inst_o), 72'h00500093);
        chk("t1_addr", 72'(inst_addr_o), 72'h0);
        chk("t1_valid", 72'(inst_valid_o), 72'd1);
        chk("t1_count", 72'(count_o), 72'd1);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("t1_drained", 72'(count_o), 72'd0);

        // 2: fill with decode stalled, 5th push ignored, pop order preserved
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1, 32'h100 + i, 32'(4 * i), 8'h00);
            tick();
        end
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        chk("t2_full_count", 72'(count_o), 72'd4);
        chk("t2_full_ready", 72'(inst_ready_o), 72'd0);
        inst_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_inst", 72'(inst_o), 72'(32'h100 + i));
            chk("t2_pop_addr", 72'(inst_addr_o), 72'(4 * i));
            tick();
        end
        inst_ready_i = 1'b0;
        chk("t2_empty", 72'(count_o), 72'd0);

        // 3: full queue streaming for 16 cycles
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'h300 + i, 32'h1000 + 32'(4 * i), 8'h00);
            tick();
        end
        inst_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_push(1'b1, 32'h200 + k, 32'h2000 + 32'(4 * k), 8'h00);
            tick();
        end
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        inst_ready_i = 1'b0;
        chk("t3_count", 72'(count_o), 72'd3);
        chk("t3_head", 72'(inst_o), 72'h20D);
        inst_ready_i = 1'b1;
        repeat (3) tick();
        inst_ready_i = 1'b0;

        // 4: hold with two entries
        set_push(1'b1, 32'h400, 32'h40, 8'h00);
        tick();
        set_push(1'b1, 32'h401, 32'h44, 8'h00);
        tick();
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        inst_ready_i = 1'b1;
        hold_flag_i  = 3'b010;
        #1;
        chk("t4_hold_valid", 72'(inst_valid_o), 72'd0);
        repeat (2) tick();
        hold_flag_i = 3'b111;
        tick();
        chk("t4_hold_head", 72'(inst_o), 72'h400);
        chk("t4_hold_count", 72'(count_o), 72'd2);
        hold_flag_i = 3'b001;
        #1;
        chk("t4_release_valid", 72'(inst_valid_o), 72'd1);
        repeat (2) tick();
        hold_flag_i  = 3'b000;
        inst_ready_i = 1'b0;

        // 5: flush with three entries and a simultaneous push
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h500 + i, 32'h50 + 32'(4 * i), 8'h00);
            tick();
        end
        set_push(1'b1, 32'h5FF, 32'h5F, 8'h00);
        flush_i      = 1'b1;
        inst_ready_i = 1'b1;
        #1;
        chk("t5_preflush_head", 72'(inst_o), 72'h500);
        tick();
        flush_i = 1'b0;
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        chk("t5_count", 72'(count_o), 72'd0);
        chk("t5_inst", 72'(inst_o), 72'(NOP));
        chk("t5_valid", 72'(inst_valid_o), 72'd0);
        repeat (2) tick();
        inst_ready_i = 1'b0;

        // 6: irq flag travels with entry 1, then a reset pulse mid-stream
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h600 + i, 32'h60 + 32'(4 * i), (i == 1) ? 8'h04 : 8'h00);
            tick();
        end
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        inst_ready_i = 1'b1;
        chk("t6_irq_e0", 72'(interrupt_flag_o), 72'h00);
        tick();
        chk("t6_irq_e1", 72'(interrupt_flag_o), 72'h04);
        chk("t6_inst_e1", 72'(inst_o), 72'h601);
        tick();
        chk("t6_irq_e2", 72'(interrupt_flag_o), 72'h00);
        inst_ready_i = 1'b0;
        set_push(1'b1, 32'h700, 32'h70, 8'h04);
        tick();
        tick();
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 72'(inst_valid_o), 72'd0);
        chk("t6_rst_count", 72'(count_o), 72'd0);
        chk("t6_rst_ready", 72'(inst_ready_o), 72'd1);
        chk("t6_rst_head", {interrupt_flag_o, inst_addr_o, inst_o}, {8'h00, 32'h0, NOP});
        tick();
        rst = 1'b0;
        set_push(1'b1, 32'h800, 32'h80, 8'h00);
        tick();
        set_push(1'b0, 32'h0, 32'h0, 8'h00);
        chk("t6_after_rst_inst", 72'(inst_o), 72'h800);
        chk("t6_after_rst_count", 72'(count_o), 72'd1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
